iob_cache_fe_arb: RTL

IOB_CACHE_FE_ARB -- requirements
Module: iob_cache_fe_arb

---
 rtl/iob_cache_fe_arb_pkg.sv | 14 +
 rtl/iob_cache_rr_sel.sv | 31 +++
 rtl/iob_reg_r.sv | 18 +
 rtl/iob_cache_fe_arb.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/iob_cache_fe_arb_pkg.sv
// Shared definitions for the cache frontend arbiter: FSM encoding and requester-count limits.
package iob_cache_fe_arb_pkg;

    localparam int N_M_MIN = 2;
    localparam int N_M_MAX = 4;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_WAIT_R = 2'd2
    } state_t;

endpackage

// File: rtl/iob_cache_rr_sel.sv
// Round-robin selector: first asserted request starting one past the last grant, one-hot plus index.
module iob_cache_rr_sel #(
    parameter int N_M   = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_M-1:0]   req,
    input  logic [IDX_W-1:0] last,
    output logic [N_M-1:0]   grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;
    logic             found;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 1; i <= N_M; i++) begin
            pos = IDX_W'((int'(last) + i) % N_M);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/iob_reg_r.sv
// Standard register primitive with synchronous active-high reset to a parameterised value.
module iob_reg_r #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/iob_cache_fe_arb.sv
// N_M-to-1 round-robin arbiter in front of a cache frontend; pure routing, at most one read in flight.
module iob_cache_fe_arb
    import iob_cache_fe_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_M    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_M-1:0]           m_valid_i,
    input  logic [N_M*ADDR_W-1:0]    m_addr_i,
    input  logic [N_M*DATA_W-1:0]    m_wdata_i,
    input  logic [N_M*DATA_W/8-1:0]  m_wstrb_i,
    output logic [N_M-1:0]           m_ready_o,
    output logic [N_M-1:0]           m_rvalid_o,
    output logic [N_M*DATA_W-1:0]    m_rdata_o,
    output logic                     s_valid_o,
    output logic [ADDR_W-1:0]        s_addr_o,
    output logic [DATA_W-1:0]        s_wdata_o,
    output logic [DATA_W/8-1:0]      s_wstrb_o,
    input  logic                     s_ready_i,
    input  logic                     s_rvalid_i,
    input  logic [DATA_W-1:0]        s_rdata_i,
    output logic                     err_o
);

    localparam int IDX_W  = $clog2(N_M);
    localparam int STRB_W = DATA_W / 8;

    if (N_M < N_M_MIN || N_M > N_M_MAX) begin : g_bad_n_m
        $error("iob_cache_fe_arb: N_M out of range");
    end

    logic [STATE_W-1:0] state_q;
    state_t             state, state_n;
    logic [IDX_W-1:0]   last_grant, last_grant_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic               err_n;

    logic [N_M-1:0]     rr_grant;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   g;
    logic               accept;
    logic               is_read;

    logic [ADDR_W-1:0]  addr_a  [N_M];
    logic [DATA_W-1:0]  wdata_a [N_M];
    logic [STRB_W-1:0]  wstrb_a [N_M];

    for (genvar k = 0; k < N_M; k++) begin : g_slice
        assign addr_a[k]  = m_addr_i[k*ADDR_W +: ADDR_W];
        assign wdata_a[k] = m_wdata_i[k*DATA_W +: DATA_W];
        assign wstrb_a[k] = m_wstrb_i[k*STRB_W +: STRB_W];
    end

    assign state = state_t'(state_q);

    iob_cache_rr_sel #(
        .N_M   (N_M),
        .IDX_W (IDX_W)
    ) u_rr_sel (
        .req   (m_valid_i),
        .last  (last_grant),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // The owner register doubles as the pinned grant while a request is held.
    assign g         = (state == ST_HOLD) ? owner : rr_idx;
    assign s_addr_o  = addr_a[g];
    assign s_wdata_o = wdata_a[g];
    assign s_wstrb_o = wstrb_a[g];
    assign m_rdata_o = {N_M{s_rdata_i}};

    assign accept  = s_valid_o & s_ready_i;
    assign is_read = (s_wstrb_o == '0);

    always_comb begin
        s_valid_o  = 1'b0;
        m_ready_o  = '0;
        m_rvalid_o = '0;
        unique case (state)
            ST_IDLE: begin
                s_valid_o = |m_valid_i;
                m_ready_o = rr_grant & {N_M{s_ready_i}};
            end
            ST_HOLD: begin
                s_valid_o        = m_valid_i[owner];
                m_ready_o[owner] = s_ready_i;
            end
            ST_WAIT_R: m_rvalid_o[owner] = s_rvalid_i;
            default: ;
        endcase
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        owner_n      = owner;
        err_n        = err_o | (s_rvalid_i & (state != ST_WAIT_R));
        unique case (state)
            ST_IDLE: begin
                if (s_valid_o) begin
                    owner_n = g;
                    if (s_ready_i) begin
                        last_grant_n = g;
                        if (is_read) state_n = ST_WAIT_R;
                    end else begin
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    last_grant_n = g;
                    state_n      = is_read ? ST_WAIT_R : ST_IDLE;
                end
            end
            ST_WAIT_R: if (s_rvalid_i) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    iob_reg_r #(.W(STATE_W), .RST_VAL(ST_IDLE)) u_state_reg (
        .clk (clk_i), .rst (rst_i), .d (state_n), .q (state_q)
    );

    iob_reg_r #(.W(IDX_W), .RST_VAL(IDX_W'(N_M - 1))) u_last_reg (
        .clk (clk_i), .rst (rst_i), .d (last_grant_n), .q (last_grant)
    );

    iob_reg_r #(.W(IDX_W), .RST_VAL('0)) u_owner_reg (
        .clk (clk_i), .rst (rst_i), .d (owner_n), .q (owner)
    );

    iob_reg_r #(.W(1), .RST_VAL(1'b0)) u_err_reg (
        .clk (clk_i), .rst (rst_i), .d (err_n), .q (err_o)
    );

endmodule
